// File: rtl/fee_reg_file_if.sv
// Command bus between the DTC command stage (master) and the FEE register file (slave).
// The handshake is a held exec level answered by a one-cycle ack.
interface fee_reg_file_if;
   logic        dtc_fpga_cmd_exec;
   logic        dtc_fpga_cmd_rnw;
   logic [7:0]  dtc_fpga_cmd_addr;
   logic [15:0] dtc_fpga_cmd_wdata;
   logic [15:0] dtc_fpga_cmd_rdata;
   logic        fpga_cmd_ack;

   modport master (
      output dtc_fpga_cmd_exec, dtc_fpga_cmd_rnw, dtc_fpga_cmd_addr, dtc_fpga_cmd_wdata,
      input  dtc_fpga_cmd_rdata, fpga_cmd_ack
   );

   modport slave (
      input  dtc_fpga_cmd_exec, dtc_fpga_cmd_rnw, dtc_fpga_cmd_addr, dtc_fpga_cmd_wdata,
      output dtc_fpga_cmd_rdata, fpga_cmd_ack
   );
endinterface

// File: rtl/fee_reg_file.sv
// FEE-side register file: decodes DTC commands into control/user registers, status reads
// and self-clearing command pulses, answering every command with a single ack.
module fee_reg_file #(
   parameter int          NUM_USER     = 8,
   parameter logic [7:0]  USER_BASE    = 8'h10,
   parameter logic [15:0] FW_VERSION   = 16'h0130,
   parameter logic [15:0] UNMAPPED_VAL = 16'hDEAD
) (
   input  logic                    rdoclk,
   input  logic                    reset,
   fee_reg_file_if.slave           bus,
   input  logic                    fee_flag,
   input  logic [15:0]             event_rdo_cnt,
   output logic                    CntRst,
   output logic [15:0]             ctrl_reg,
   output logic [16*NUM_USER-1:0]  user_regs
);

   localparam int IDX_W = (NUM_USER > 1) ? $clog2(NUM_USER) : 1;

   localparam logic [7:0] ADDR_VERSION = 8'h00;
   localparam logic [7:0] ADDR_CTRL    = 8'h01;
   localparam logic [7:0] ADDR_STATUS  = 8'h02;
   localparam logic [7:0] ADDR_EVCNT   = 8'h03;
   localparam logic [7:0] ADDR_CMD     = 8'h04;
   localparam logic [7:0] ADDR_ERRCNT  = 8'h05;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      ACK,
      WAIT_LOW
   } state_t;

   state_t state, state_nxt;

   logic             exec_d;
   logic             exec_rise;
   logic             cmd_rnw;
   logic [7:0]       cmd_addr;
   logic [15:0]      cmd_wdata;
   logic [15:0]      err_cnt;
   logic [15:0]      user_q [NUM_USER];

   logic [15:0]      rd_mux;
   logic             addr_mapped;
   logic             addr_ro;
   logic             user_hit;
   logic [IDX_W-1:0] user_idx;
   logic             cmd_err;
   logic             do_write;

   assign exec_rise = bus.dtc_fpga_cmd_exec & ~exec_d;

   // ------------------------------------------------------------------
   // Command FSM
   // ------------------------------------------------------------------
   always_ff @(posedge rdoclk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every variable gets a default before the case so no path can leave it
   // unassigned; a missing default in always_comb infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (exec_rise) state_nxt = EXEC;
         EXEC:     state_nxt = ACK;
         ACK:      state_nxt = WAIT_LOW;
         WAIT_LOW: if (!bus.dtc_fpga_cmd_exec) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   assign bus.fpga_cmd_ack = (state == ACK);

   // ------------------------------------------------------------------
   // Address decode on the latched command
   // ------------------------------------------------------------------
   always_comb begin
      rd_mux      = UNMAPPED_VAL;
      addr_mapped = 1'b1;
      addr_ro     = 1'b0;
      user_hit    = 1'b0;
      user_idx    = IDX_W'(cmd_addr - USER_BASE);

      if ({1'b0, cmd_addr} >= {1'b0, USER_BASE} &&
          {1'b0, cmd_addr} <  {1'b0, USER_BASE} + 9'(NUM_USER)) begin
         user_hit = 1'b1;
         rd_mux   = user_q[user_idx];
      end else begin
         case (cmd_addr)
            ADDR_VERSION: begin rd_mux = FW_VERSION;             addr_ro = 1'b1; end
            ADDR_CTRL:          rd_mux = ctrl_reg;
            ADDR_STATUS:  begin rd_mux = {15'b0, fee_flag};      addr_ro = 1'b1; end
            ADDR_EVCNT:   begin rd_mux = event_rdo_cnt;          addr_ro = 1'b1; end
            ADDR_CMD:           rd_mux = 16'h0000;
            ADDR_ERRCNT:  begin rd_mux = err_cnt;                addr_ro = 1'b1; end
            default:            addr_mapped = 1'b0;
         endcase
      end
   end

   assign do_write = (state == EXEC) && !cmd_rnw;
   assign cmd_err  = (state == EXEC) && (!addr_mapped || (!cmd_rnw && addr_ro));

   // ------------------------------------------------------------------
   // Datapath: command latch, register writes, read data, pulses, errors
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge rdoclk) begin
      if (!reset) begin
         exec_d                 <= 1'b0;
         cmd_rnw                <= 1'b0;
         cmd_addr               <= '0;
         cmd_wdata              <= '0;
         bus.dtc_fpga_cmd_rdata <= '0;
         CntRst                 <= 1'b0;
         ctrl_reg               <= '0;
         err_cnt                <= '0;
         // NOTE: the user bank is a handful of flops that must read back as zero
         // after reset, so it is cleared explicitly rather than left as a RAM.
         for (int i = 0; i < NUM_USER; i++) user_q[i] <= '0;
      end else begin
         exec_d <= bus.dtc_fpga_cmd_exec;
         CntRst <= 1'b0;

         if (state == IDLE && exec_rise) begin
            cmd_rnw   <= bus.dtc_fpga_cmd_rnw;
            cmd_addr  <= bus.dtc_fpga_cmd_addr;
            cmd_wdata <= bus.dtc_fpga_cmd_wdata;
         end

         if (state == EXEC && cmd_rnw) bus.dtc_fpga_cmd_rdata <= rd_mux;

         if (do_write) begin
            if (user_hit)                           user_q[user_idx] <= cmd_wdata;
            else if (cmd_addr == ADDR_CTRL)         ctrl_reg         <= cmd_wdata;
            else if (cmd_addr == ADDR_CMD && cmd_wdata[0]) CntRst    <= 1'b1;
         end

         // Counter clear takes priority over a same-cycle error increment.
         if (CntRst)                              err_cnt <= '0;
         else if (cmd_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
   end

   for (genvar g = 0; g < NUM_USER; g++) begin : g_user_flat
      assign user_regs[16*g +: 16] = user_q[g];
   end

endmodule

// File: tb/tb_fee_reg_file.sv
// Directed self-checking bench for fee_reg_file: map, ack timing, errors, CntRst, reset abort.
module tb_fee_reg_file;

   logic         rdoclk = 1'b0;
   logic         reset  = 1'b0;
   logic         fee_flag = 1'b0;
   logic [15:0]  event_rdo_cnt = '0;
   logic         CntRst;
   logic [15:0]  ctrl_reg;
   logic [127:0] user_regs;

   int passes = 0;
   int checks = 0;

   // Observations captured by do_cmd
   logic [15:0] rd_val;
   int          ack_cnt, ack_lat, rst_cnt, rst_lat;
   logic [15:0] ctrl_at2;

   fee_reg_file_if bus ();

   fee_reg_file dut (
      .rdoclk        (rdoclk),
      .reset         (reset),
      .bus           (bus),
      .fee_flag      (fee_flag),
      .event_rdo_cnt (event_rdo_cnt),
      .CntRst        (CntRst),
      .ctrl_reg      (ctrl_reg),
      .user_regs     (user_regs)
   );

   always #5 rdoclk = ~rdoclk;

   task automatic tick();
      @(posedge rdoclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Raise exec for 'hold' cycles and watch ack/CntRst for a bounded window.
   task automatic do_cmd(input logic rnw, input logic [7:0] addr, input logic [15:0] wdata,
                         input int hold);
      bus.dtc_fpga_cmd_exec  = 1'b1;
      bus.dtc_fpga_cmd_rnw   = rnw;
      bus.dtc_fpga_cmd_addr  = addr;
      bus.dtc_fpga_cmd_wdata = wdata;
      ack_cnt = 0; ack_lat = -1; rst_cnt = 0; rst_lat = -1;
      rd_val = 'x; ctrl_at2 = 'x;
      for (int i = 1; i <= hold + 6; i++) begin
         tick();
         if (i == hold) bus.dtc_fpga_cmd_exec = 1'b0;
         if (i == 2) ctrl_at2 = ctrl_reg;
         if (bus.fpga_cmd_ack === 1'b1) begin
            if (ack_cnt == 0) begin ack_lat = i; rd_val = bus.dtc_fpga_cmd_rdata; end
            ack_cnt++;
         end
         if (CntRst === 1'b1) begin
            if (rst_cnt == 0) rst_lat = i;
            rst_cnt++;
         end
      end
      bus.dtc_fpga_cmd_exec = 1'b0;
   endtask

   task automatic rd(input logic [7:0] addr, input logic [15:0] exp, input string tag);
      do_cmd(1'b1, addr, 16'h0000, 3);
      check({tag, "_ack"}, ack_cnt, 1);
      check(tag, rd_val, exp);
   endtask

   task automatic wr(input logic [7:0] addr, input logic [15:0] data, input string tag);
      do_cmd(1'b0, addr, data, 3);
      check({tag, "_ack"}, ack_cnt, 1);
   endtask

   initial begin
      logic [127:0] exp_user;

      bus.dtc_fpga_cmd_exec  = 1'b0;
      bus.dtc_fpga_cmd_rnw   = 1'b0;
      bus.dtc_fpga_cmd_addr  = '0;
      bus.dtc_fpga_cmd_wdata = '0;

      // Reset state
      repeat (3) tick();
      check("rst_rdata",  bus.dtc_fpga_cmd_rdata, 16'h0000);
      check("rst_ack",    bus.fpga_cmd_ack, 1'b0);
      check("rst_cntrst", CntRst, 1'b0);
      check("rst_ctrl",   ctrl_reg, 16'h0000);
      check("rst_user",   user_regs, 128'h0);
      reset = 1'b1;
      tick();

      // Version read with ack latency, then CTRL reset value
      do_cmd(1'b1, 8'h00, 16'h0000, 4);
      check("ver_ack_cnt", ack_cnt, 1);
      check("ver_ack_lat", ack_lat, 2);
      check("ver_rdata",   rd_val, 16'h0130);
      rd(8'h01, 16'h0000, "ctrl_rst_rd");

      // CTRL write with exec held 12 cycles
      do_cmd(1'b0, 8'h01, 16'hA5C3, 12);
      check("ctrl_wr_ack_cnt", ack_cnt, 1);
      check("ctrl_wr_ack_lat", ack_lat, 2);
      check("ctrl_at_t2",      ctrl_at2, 16'hA5C3);
      check("rdata_kept_on_wr", bus.dtc_fpga_cmd_rdata, 16'h0000);
      do_cmd(1'b1, 8'h01, 16'h0000, 12);
      check("ctrl_rd_ack_cnt", ack_cnt, 1);
      check("ctrl_rd",         rd_val, 16'hA5C3);

      // User registers
      exp_user = '0;
      for (int i = 0; i < 8; i++) begin
         wr(8'(8'h10 + i), 16'(16'h1000 + i), "user_wr");
         exp_user[16*i +: 16] = 16'(16'h1000 + i);
      end
      check("user_flat", user_regs, exp_user);
      for (int i = 0; i < 8; i++) rd(8'(8'h10 + i), 16'(16'h1000 + i), "user_rd");
      rd(8'h18, 16'hDEAD, "unmapped_rd");
      rd(8'h05, 16'h0001, "errcnt_one");

      // Status, event count, CntRst command
      event_rdo_cnt = 16'h0042;
      fee_flag      = 1'b1;
      rd(8'h03, 16'h0042, "evcnt_rd");
      rd(8'h02, 16'h0001, "status_rd");
      do_cmd(1'b0, 8'h04, 16'h0001, 3);
      check("cntrst_pulses", rst_cnt, 1);
      check("cntrst_lat",    rst_lat, 2);
      rd(8'h05, 16'h0000, "errcnt_cleared");
      rd(8'h04, 16'h0000, "cmd_rd_zero");
      do_cmd(1'b0, 8'h04, 16'h0000, 3);
      check("cntrst_bit0_clear", rst_cnt, 0);

      // Short exec pulse still completes
      do_cmd(1'b1, 8'h00, 16'h0000, 1);
      check("short_ack_cnt", ack_cnt, 1);
      check("short_rdata",   rd_val, 16'h0130);

      // Error counter saturation: preload near the top, then erroneous writes
      force dut.err_cnt = 16'hFFFD;
      tick();
      release dut.err_cnt;
      wr(8'h00, 16'h1111, "ro_wr1");
      rd(8'h05, 16'hFFFE, "errcnt_fffe");
      wr(8'h00, 16'h2222, "ro_wr2");
      wr(8'h03, 16'h3333, "ro_wr3");
      rd(8'h05, 16'hFFFF, "errcnt_sat");
      wr(8'h20, 16'h4444, "unmapped_wr");
      rd(8'h05, 16'hFFFF, "errcnt_sat_hold");
      wr(8'h04, 16'h0001, "cntrst_wr2");
      rd(8'h05, 16'h0000, "errcnt_clr_sat");

      // Reset during EXEC of a CTRL write aborts it
      bus.dtc_fpga_cmd_exec  = 1'b1;
      bus.dtc_fpga_cmd_rnw   = 1'b0;
      bus.dtc_fpga_cmd_addr  = 8'h01;
      bus.dtc_fpga_cmd_wdata = 16'h1234;
      tick();
      reset = 1'b0;
      bus.dtc_fpga_cmd_exec = 1'b0;
      ack_cnt = 0;
      tick();
      if (bus.fpga_cmd_ack === 1'b1) ack_cnt++;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.fpga_cmd_ack === 1'b1) ack_cnt++;
      end
      check("abort_no_ack", ack_cnt, 0);
      check("abort_ctrl",   ctrl_reg, 16'h0000);
      wr(8'h01, 16'h1234, "post_rst_wr");
      rd(8'h01, 16'h1234, "post_rst_rd");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
